alu_output_stage: RTL

- Output stage directly downstream of the 48-bit SIMD ALU.
- Optionally registers the ALU sum S and its 4 segment carry-outs into P/CARRYOUT; P is also the accumulator feedback source for the ALU X/Z muxes.
- Performs masked pattern / inverted-pattern detection with overflow/underflow flags, plus optional auto-reset of P on detect.
- Configured through the same serial configuration shift chain as the ALU.

---
 rtl/alu_output_stage.sv | 106 ++++++++++
 1 files changed

// File: rtl/alu_output_stage.sv
// rtl/alu_output_stage.sv - ALU output stage: optional P/CARRYOUT register, masked pattern detect,
// overflow/underflow flags and auto-reset, configured through a 5-bit serial shift chain.
module alu_output_stage #(
  parameter logic [47:0] PATTERN = 48'h000000000000,
  parameter logic [47:0] MASK    = 48'h3FFFFFFFFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        CEP,
  input  logic [47:0] S,
  input  logic [3:0]  CARRYOUT_in,
  output logic [47:0] P,
  output logic [3:0]  CARRYOUT,
  output logic        PATTERNDETECT,
  output logic        PATTERNBDETECT,
  output logic        OVERFLOW,
  output logic        UNDERFLOW,
  input  logic        configuration_input,
  input  logic        configuration_enable,
  output logic        configuration_output
);

  logic        preg;
  logic [1:0]  use_simd;
  logic [1:0]  autoreset;

  logic [3:0]  cq;
  logic        pd;
  logic        pbd;

  logic [47:0] p_q;
  logic [3:0]  co_q;
  logic        pd_q;
  logic        pbd_q;
  logic        pd_past;
  logic        pbd_past;

  logic        pd_sel;
  logic        pbd_sel;
  logic        ar_fire;

  // Config chain is independent of rst and CEP; first bit in lands in autoreset[1].
  always_ff @(posedge clk) begin
    if (configuration_enable) begin
      preg      <= configuration_input;
      use_simd  <= {use_simd[0], preg};
      autoreset <= {autoreset[0], use_simd[1]};
    end
  end

  assign configuration_output = autoreset[1];

  always_comb begin
    cq = {CARRYOUT_in[3], 3'b000};
    case (use_simd)
      2'b01:   cq = {CARRYOUT_in[3], 1'b0, CARRYOUT_in[1], 1'b0};
      2'b10:   cq = CARRYOUT_in;
      default: cq = {CARRYOUT_in[3], 3'b000};
    endcase
  end

  assign pd  = &(~(S ^ PATTERN) | MASK);
  assign pbd = &(~(S ^ ~PATTERN) | MASK);

  assign pd_sel  = preg ? pd_q  : pd;
  assign pbd_sel = preg ? pbd_q : pbd;

  // Auto-reset only exists when P is registered; encoding 11 acts as disabled.
  assign ar_fire = preg &&
                   (((autoreset == 2'b01) && pd_q) ||
                    ((autoreset == 2'b10) && !pd_q && pd_past));

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q      <= '0;
      co_q     <= '0;
      pd_q     <= 1'b0;
      pbd_q    <= 1'b0;
      pd_past  <= 1'b0;
      pbd_past <= 1'b0;
    end else if (CEP) begin
      pd_past  <= pd_sel;
      pbd_past <= pbd_sel;
      if (ar_fire) begin
        p_q   <= '0;
        co_q  <= '0;
        pd_q  <= 1'b0;
        pbd_q <= 1'b0;
      end else begin
        p_q   <= S;
        co_q  <= cq;
        pd_q  <= pd;
        pbd_q <= pbd;
      end
    end
  end

  assign P              = preg ? p_q  : S;
  assign CARRYOUT       = preg ? co_q : cq;
  assign PATTERNDETECT  = pd_sel;
  assign PATTERNBDETECT = pbd_sel;

  assign OVERFLOW  = pd_past  & ~pd_sel & ~pbd_sel;
  assign UNDERFLOW = pbd_past & ~pd_sel & ~pbd_sel;

endmodule
